// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_pkg : shared types and constants for the pipeline sequencer
// Rev 1.0
// ============================================================================
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_t;

  // addi x0, x0, 0 -- what a cleared pipeline register holds
  localparam logic [31:0] c_nop_instr = 32'h0000_0013;
  localparam logic [4:0]  c_x0        = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : datapath <-> hazard controller signal bundle
// Rev 1.0
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  import hazard_ctrl_pkg::*;

  logic [4:0]       rs1_ID, rs2_ID, rs1_EX, rs2_EX;
  logic [4:0]       IDEX_rd, EXMEM_rd, MEMWB_rd;
  logic             IDEX_MemRead, EXMEM_RegWrite, EXMEM_MemtoReg, MEMWB_RegWrite;
  logic             PCSrc_EX, mem_access, mem_ready;
  logic             EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB;
  logic             clear_IFID, clear_IDEX, clear_EXMEM, clear_MEMWB;
  fwd_sel_t         fwdA, fwdB;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs1_ID, rs2_ID, rs1_EX, rs2_EX, IDEX_rd, EXMEM_rd, MEMWB_rd,
           IDEX_MemRead, EXMEM_RegWrite, EXMEM_MemtoReg, MEMWB_RegWrite,
           PCSrc_EX, mem_access, mem_ready,
    input  EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB,
           clear_IFID, clear_IDEX, clear_EXMEM, clear_MEMWB,
           fwdA, fwdB, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_EX, rs2_EX, IDEX_rd, EXMEM_rd, MEMWB_rd,
           IDEX_MemRead, EXMEM_RegWrite, EXMEM_MemtoReg, MEMWB_RegWrite,
           PCSrc_EX, mem_access, mem_ready,
    output EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB,
           clear_IFID, clear_IDEX, clear_EXMEM, clear_MEMWB,
           fwdA, fwdB, mem_timeout, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_forward_unit.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_forward_unit : EX operand bypass select for one source register
// Rev 1.0
// ============================================================================
module hazard_ctrl_forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_exmem_rd,
  input  logic       i_exmem_regwrite,
  input  logic       i_exmem_memtoreg,
  input  logic [4:0] i_memwb_rd,
  input  logic       i_memwb_regwrite,
  output fwd_sel_t   o_sel
);

  // A load in MEM has no data yet, so only ALU results bypass from EXMEM
  always_comb begin
    o_sel = FWD_REG;
    if (i_rs != c_x0) begin
      if (i_exmem_regwrite && !i_exmem_memtoreg && (i_exmem_rd == i_rs))
        o_sel = FWD_MEM;
      else if (i_memwb_regwrite && (i_memwb_rd == i_rs))
        o_sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : stage enables, bubble strobes, forwarding and MEM wait states
// Rev 1.0
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic          CLOCK,
  input  logic          RST_n,
  hazard_ctrl_if.slave  hz
);

  localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT_CYC);

  hz_state_t        r_state, w_state_nxt;
  logic [TO_W-1:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_load_use_hz, w_frozen, w_flush, w_load_use, w_timeout_hit;
  logic w_en_pc, w_en_ifid, w_en_idex, w_en_exmem, w_en_memwb;
  logic w_clr_ifid, w_clr_idex, w_clr_exmem, w_clr_memwb;

  assign w_load_use_hz = hz.IDEX_MemRead && (hz.IDEX_rd != c_x0) &&
                         ((hz.IDEX_rd == hz.rs1_ID) || (hz.IDEX_rd == hz.rs2_ID));

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_frozen       = 1'b0;
    w_flush        = 1'b0;
    w_load_use     = 1'b0;
    w_timeout_hit  = 1'b0;
    w_en_pc        = 1'b1;
    w_en_ifid      = 1'b1;
    w_en_idex      = 1'b1;
    w_en_exmem     = 1'b1;
    w_en_memwb     = 1'b1;
    w_clr_ifid     = 1'b1;
    w_clr_idex     = 1'b1;
    w_clr_exmem    = 1'b1;
    w_clr_memwb    = 1'b1;

    // Outputs sit at their idle values while reset is held
    if (RST_n) begin
      case (r_state)
        HZ_RUN: begin
          if (hz.mem_access && !hz.mem_ready) begin
            w_frozen       = 1'b1;
            w_state_nxt    = HZ_MEM_WAIT;
            w_wait_cnt_nxt = TO_W'(1);
          end
        end
        HZ_MEM_WAIT: begin
          if (hz.mem_ready) begin
            w_state_nxt    = HZ_RUN;
            w_wait_cnt_nxt = '0;
          end else if (r_wait_cnt == c_timeout) begin
            w_state_nxt    = HZ_RUN;
            w_wait_cnt_nxt = '0;
            w_timeout_hit  = 1'b1;
          end else begin
            w_frozen       = 1'b1;
            w_wait_cnt_nxt = r_wait_cnt + TO_W'(1);
          end
        end
        default: w_state_nxt = HZ_RUN;
      endcase

      // Freeze holds a pending branch in IDEX; it fires on the release cycle
      if (w_frozen) begin
        w_en_pc     = 1'b0;
        w_en_ifid   = 1'b0;
        w_en_idex   = 1'b0;
        w_en_exmem  = 1'b0;
        w_clr_memwb = 1'b0;
      end else if (hz.PCSrc_EX) begin
        w_flush    = 1'b1;
        w_clr_ifid = 1'b0;
        w_clr_idex = 1'b0;
      end else if (w_load_use_hz) begin
        w_load_use = 1'b1;
        w_en_pc    = 1'b0;
        w_en_ifid  = 1'b0;
        w_clr_idex = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      r_state       <= HZ_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_hit)
        r_mem_timeout <= 1'b1;
      if (w_frozen || w_load_use)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  hazard_ctrl_forward_unit u_fwd_a (
    .i_rs             (hz.rs1_EX),
    .i_exmem_rd       (hz.EXMEM_rd),
    .i_exmem_regwrite (hz.EXMEM_RegWrite),
    .i_exmem_memtoreg (hz.EXMEM_MemtoReg),
    .i_memwb_rd       (hz.MEMWB_rd),
    .i_memwb_regwrite (hz.MEMWB_RegWrite),
    .o_sel            (hz.fwdA)
  );

  hazard_ctrl_forward_unit u_fwd_b (
    .i_rs             (hz.rs2_EX),
    .i_exmem_rd       (hz.EXMEM_rd),
    .i_exmem_regwrite (hz.EXMEM_RegWrite),
    .i_exmem_memtoreg (hz.EXMEM_MemtoReg),
    .i_memwb_rd       (hz.MEMWB_rd),
    .i_memwb_regwrite (hz.MEMWB_RegWrite),
    .o_sel            (hz.fwdB)
  );

  assign hz.EN_PC       = w_en_pc;
  assign hz.EN_IFID     = w_en_ifid;
  assign hz.EN_IDEX     = w_en_idex;
  assign hz.EN_EXMEM    = w_en_exmem;
  assign hz.EN_MEMWB    = w_en_memwb;
  assign hz.clear_IFID  = w_clr_ifid;
  assign hz.clear_IDEX  = w_clr_idex;
  assign hz.clear_EXMEM = w_clr_exmem;
  assign hz.clear_MEMWB = w_clr_memwb;
  assign hz.mem_timeout = r_mem_timeout;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed-vector bench for hazard_ctrl (TIMEOUT_CYC = 4)
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic CLOCK = 1'b0;
  logic RST_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  always #5 CLOCK = ~CLOCK;

  hazard_ctrl_if #(.CNT_W(32)) hz_if ();

  hazard_ctrl #(.TIMEOUT_CYC(4), .TO_W(8), .CNT_W(32)) dut (
    .CLOCK (CLOCK),
    .RST_n (RST_n),
    .hz    (hz_if)
  );

  // {EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB}
  function automatic logic [4:0] en_v();
    en_v = {hz_if.EN_PC, hz_if.EN_IFID, hz_if.EN_IDEX, hz_if.EN_EXMEM, hz_if.EN_MEMWB};
  endfunction

  // {clear_IFID, clear_IDEX, clear_EXMEM, clear_MEMWB}
  function automatic logic [3:0] clr_v();
    clr_v = {hz_if.clear_IFID, hz_if.clear_IDEX, hz_if.clear_EXMEM, hz_if.clear_MEMWB};
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    hz_if.rs1_ID = 5'd0; hz_if.rs2_ID = 5'd0; hz_if.rs1_EX = 5'd0; hz_if.rs2_EX = 5'd0;
    hz_if.IDEX_rd = 5'd0; hz_if.EXMEM_rd = 5'd0; hz_if.MEMWB_rd = 5'd0;
    hz_if.IDEX_MemRead = 1'b0; hz_if.EXMEM_RegWrite = 1'b0;
    hz_if.EXMEM_MemtoReg = 1'b0; hz_if.MEMWB_RegWrite = 1'b0;
    hz_if.PCSrc_EX = 1'b0; hz_if.mem_access = 1'b0; hz_if.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #3;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL reset_en: got %b want 11111", en_v()); end
    n_vec++; if (clr_v() !== 4'b1111) begin n_err++; $display("FAIL reset_clr: got %b want 1111", clr_v()); end
    n_vec++; if ({hz_if.fwdA, hz_if.fwdB} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b want 0000", {hz_if.fwdA, hz_if.fwdB}); end
    n_vec++; if (hz_if.mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", hz_if.mem_timeout); end
    n_vec++; if ({hz_if.stall_cnt, hz_if.flush_cnt} !== 64'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", hz_if.stall_cnt, hz_if.flush_cnt); end
    step();
    step();
    RST_n = 1'b1;
  endtask

  task automatic test_load_use();
    idle();
    hz_if.IDEX_MemRead = 1'b1; hz_if.IDEX_rd = 5'd5; hz_if.rs1_ID = 5'd5;
    #1;
    n_vec++; if (en_v() !== 5'b00111) begin n_err++; $display("FAIL lu_rs1_en: got %b want 00111", en_v()); end
    n_vec++; if (clr_v() !== 4'b1011) begin n_err++; $display("FAIL lu_rs1_clr: got %b want 1011", clr_v()); end
    step(); exp_stall = 1;
    n_vec++; if (hz_if.stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL lu_stall1: got %0d want %0d", hz_if.stall_cnt, exp_stall); end
    hz_if.rs1_ID = 5'd0; hz_if.rs2_ID = 5'd5;
    #1;
    n_vec++; if (en_v() !== 5'b00111) begin n_err++; $display("FAIL lu_rs2_en: got %b want 00111", en_v()); end
    step(); exp_stall = 2;
    n_vec++; if (hz_if.stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL lu_stall2: got %0d want %0d", hz_if.stall_cnt, exp_stall); end
    hz_if.IDEX_rd = 5'd0; hz_if.rs2_ID = 5'd0;
    #1;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL lu_x0_en: got %b want 11111", en_v()); end
    hz_if.IDEX_rd = 5'd5; hz_if.rs1_ID = 5'd6; hz_if.rs2_ID = 5'd7;
    #1;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL lu_nomatch_en: got %b want 11111", en_v()); end
    hz_if.IDEX_MemRead = 1'b0; hz_if.rs1_ID = 5'd5;
    #1;
    n_vec++; if (clr_v() !== 4'b1111) begin n_err++; $display("FAIL lu_noload_clr: got %b want 1111", clr_v()); end
    step();
    n_vec++; if (hz_if.stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL lu_stall_hold: got %0d want %0d", hz_if.stall_cnt, exp_stall); end
  endtask

  task automatic test_forwarding();
    idle();
    hz_if.EXMEM_rd = 5'd7; hz_if.MEMWB_rd = 5'd7;
    hz_if.EXMEM_RegWrite = 1'b1; hz_if.MEMWB_RegWrite = 1'b1; hz_if.rs2_EX = 5'd7;
    #1;
    n_vec++; if (hz_if.fwdB !== FWD_MEM) begin n_err++; $display("FAIL fwdB_mem: got %b want 10", hz_if.fwdB); end
    hz_if.EXMEM_MemtoReg = 1'b1;
    #1;
    n_vec++; if (hz_if.fwdB !== FWD_WB) begin n_err++; $display("FAIL fwdB_load: got %b want 01", hz_if.fwdB); end
    hz_if.rs2_EX = 5'd0;
    #1;
    n_vec++; if (hz_if.fwdB !== FWD_REG) begin n_err++; $display("FAIL fwdB_x0: got %b want 00", hz_if.fwdB); end
    hz_if.EXMEM_MemtoReg = 1'b0; hz_if.MEMWB_rd = 5'd3; hz_if.rs1_EX = 5'd7;
    #1;
    n_vec++; if (hz_if.fwdA !== FWD_MEM) begin n_err++; $display("FAIL fwdA_mem: got %b want 10", hz_if.fwdA); end
    hz_if.EXMEM_RegWrite = 1'b0;
    #1;
    n_vec++; if (hz_if.fwdA !== FWD_REG) begin n_err++; $display("FAIL fwdA_nowr: got %b want 00", hz_if.fwdA); end
    hz_if.rs1_EX = 5'd3;
    #1;
    n_vec++; if (hz_if.fwdA !== FWD_WB) begin n_err++; $display("FAIL fwdA_wb: got %b want 01", hz_if.fwdA); end
    step();
  endtask

  task automatic test_branch();
    idle();
    hz_if.PCSrc_EX = 1'b1;
    #1;
    n_vec++; if (clr_v() !== 4'b0011) begin n_err++; $display("FAIL br_clr: got %b want 0011", clr_v()); end
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL br_en: got %b want 11111", en_v()); end
    step(); exp_flush = 1;
    n_vec++; if (hz_if.flush_cnt !== 32'(exp_flush)) begin n_err++; $display("FAIL br_flush_cnt: got %0d want %0d", hz_if.flush_cnt, exp_flush); end
    hz_if.PCSrc_EX = 1'b0;
    #1;
    n_vec++; if (clr_v() !== 4'b1111) begin n_err++; $display("FAIL br_after_clr: got %b want 1111", clr_v()); end
  endtask

  task automatic test_priority();
    idle();
    hz_if.PCSrc_EX = 1'b1; hz_if.IDEX_MemRead = 1'b1; hz_if.IDEX_rd = 5'd5; hz_if.rs1_ID = 5'd5;
    #1;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL prio_en: got %b want 11111", en_v()); end
    n_vec++; if (clr_v() !== 4'b0011) begin n_err++; $display("FAIL prio_clr: got %b want 0011", clr_v()); end
    step(); exp_flush = 2;
    n_vec++; if (hz_if.flush_cnt !== 32'(exp_flush)) begin n_err++; $display("FAIL prio_flush_cnt: got %0d want %0d", hz_if.flush_cnt, exp_flush); end
    n_vec++; if (hz_if.stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL prio_stall_cnt: got %0d want %0d", hz_if.stall_cnt, exp_stall); end
  endtask

  task automatic test_mem_wait();
    idle();
    hz_if.mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) hz_if.PCSrc_EX = 1'b1;
      #1;
      n_vec++; if (en_v() !== 5'b00001) begin n_err++; $display("FAIL mw_en[%0d]: got %b want 00001", i, en_v()); end
      n_vec++; if (clr_v() !== 4'b1110) begin n_err++; $display("FAIL mw_clr[%0d]: got %b want 1110", i, clr_v()); end
      step(); exp_stall++;
      n_vec++; if ({hz_if.stall_cnt, hz_if.flush_cnt} !== {32'(exp_stall), 32'(exp_flush)}) begin
        n_err++; $display("FAIL mw_cnt[%0d]: got %0d/%0d want %0d/%0d", i, hz_if.stall_cnt, hz_if.flush_cnt, exp_stall, exp_flush);
      end
    end
    hz_if.mem_ready = 1'b1;
    #1;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL mw_rel_en: got %b want 11111", en_v()); end
    n_vec++; if (clr_v() !== 4'b0011) begin n_err++; $display("FAIL mw_rel_clr: got %b want 0011", clr_v()); end
    step(); exp_flush++;
    n_vec++; if ({hz_if.stall_cnt, hz_if.flush_cnt} !== {32'(exp_stall), 32'(exp_flush)}) begin
      n_err++; $display("FAIL mw_rel_cnt: got %0d/%0d want %0d/%0d", hz_if.stall_cnt, hz_if.flush_cnt, exp_stall, exp_flush);
    end
    idle();
    #1;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL mw_run_en: got %b want 11111", en_v()); end
  endtask

  task automatic test_timeout();
    idle();
    hz_if.mem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (en_v() !== 5'b00001) begin n_err++; $display("FAIL to_en[%0d]: got %b want 00001", i, en_v()); end
      n_vec++; if (hz_if.mem_timeout !== 1'b0) begin n_err++; $display("FAIL to_early[%0d]: got %b want 0", i, hz_if.mem_timeout); end
      step(); exp_stall++;
    end
    #1;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL to_rel_en: got %b want 11111", en_v()); end
    step();
    n_vec++; if (hz_if.mem_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b want 1", hz_if.mem_timeout); end
    n_vec++; if (hz_if.stall_cnt !== 32'(exp_stall)) begin n_err++; $display("FAIL to_stall_cnt: got %0d want %0d", hz_if.stall_cnt, exp_stall); end
    idle();
    step();
    step();
    n_vec++; if (hz_if.mem_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", hz_if.mem_timeout); end
  endtask

  task automatic test_reset_mid_wait();
    idle();
    hz_if.mem_access = 1'b1;
    step();
    step();
    #2;
    RST_n = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0;
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL rst_mid_en: got %b want 11111", en_v()); end
    n_vec++; if (hz_if.mem_timeout !== 1'b0) begin n_err++; $display("FAIL rst_mid_timeout: got %b want 0", hz_if.mem_timeout); end
    n_vec++; if ({hz_if.stall_cnt, hz_if.flush_cnt} !== 64'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", hz_if.stall_cnt, hz_if.flush_cnt); end
    step();
    hz_if.mem_access = 1'b0;
    RST_n = 1'b1;
    step();
    n_vec++; if (en_v() !== 5'b11111) begin n_err++; $display("FAIL rst_mid_run: got %b want 11111", en_v()); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_priority();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
